// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the NOP word used on fetch abort, IR field positions and the PC step.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;   // sll $0,$0,0
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam int          OP_MSB   = 31;
    localparam int          OP_LSB   = 26;
    localparam int          FUN_MSB  = 5;
    localparam int          FUN_LSB  = 0;

    // Fetch addresses are word aligned; stray low bits are dropped, not trapped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: memory request/response, IR presentation to the
// control decoder, and the retire/redirect feedback from execute.
// master = fetch unit side, slave = memory/control side.
interface instr_fetch_unit_if;

    logic        MIO_ready;
    logic [31:0] inst_in;
    logic        mem_req;
    logic [31:0] PC_out;
    logic [31:0] inst_out;
    logic [5:0]  OPcode;
    logic [5:0]  Fun;
    logic        ir_valid;
    logic        inst_done;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    modport master (
        input  MIO_ready, inst_in, inst_done, redirect, redirect_pc,
        output mem_req, PC_out, inst_out, OPcode, Fun, ir_valid, fetch_err
    );

    modport slave (
        output MIO_ready, inst_in, inst_done, redirect, redirect_pc,
        input  mem_req, PC_out, inst_out, OPcode, Fun, ir_valid, fetch_err
    );

endinterface

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// fetch_timeout_ctr: counts consecutive S_REQ cycles and flags the cycle in
// which the request has been outstanding for TIMEOUT cycles. The count is
// held at zero whenever the FSM is outside S_REQ, so every entry starts fresh.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_req,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    // Count while requesting, clear otherwise.
    always_ff @(posedge clk) begin
        if (rst || !in_req) cnt <= '0;
        else                cnt <= cnt + 1'b1;
    end

    assign expired = in_req && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch stage. Holds PC, requests a word over
// MIO, latches it into IR and presents OPcode/Fun until execute retires it.
// Optional build macro FETCH_TIMEOUT_EN: abort a stalled request after
// TIMEOUT cycles, retire a NOP in its place and pulse fetch_err.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_unit_if.master    bus
);

    if ((RESET_PC[1:0] != 2'b00) || (TIMEOUT < 1)) begin : g_cfg_check
        $error("instr_fetch_unit: RESET_PC must be word aligned and TIMEOUT >= 1");
    end

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         ir_valid_q;
    logic         err_q, err_d;
    logic         timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .in_req  (state_q == S_REQ),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic: each state reacts only to its own event.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.MIO_ready) begin
                    ir_d    = bus.inst_in;
                    state_d = S_HOLD;
                end else if (timeout_hit) begin
                    ir_d    = NOP_INST;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.inst_done) begin
                    pc_d    = bus.redirect ? align_pc(bus.redirect_pc) : pc_q + PC_STEP;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, PC, IR and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= (state_d == S_HOLD);
            err_q      <= err_d;
        end
    end

    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.PC_out    = pc_q;
    assign bus.inst_out  = ir_q;
    assign bus.OPcode    = ir_q[OP_MSB:OP_LSB];
    assign bus.Fun       = ir_q[FUN_MSB:FUN_LSB];
    assign bus.ir_valid  = ir_valid_q;
    assign bus.fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, every
// cycle compared against a transaction-level model of the fetch protocol.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: what the fetch unit is doing in protocol terms.
    // phase 0 = dead cycle after reset, 1 = waiting for a word, 2 = word held.
    bit          m_known = 0;
    int          m_phase;
    logic [31:0] m_pc, m_ir;
    bit          m_err;
    int          m_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        if (m_known) begin
            chk("mem_req",   32'(bus.mem_req),   32'(m_phase == 1));
            chk("ir_valid",  32'(bus.ir_valid),  32'(m_phase == 2));
            chk("PC_out",    bus.PC_out,         m_pc);
            chk("inst_out",  bus.inst_out,       m_ir);
            chk("OPcode",    32'(bus.OPcode),    32'(m_ir >> 26));
            chk("Fun",       32'(bus.Fun),       32'(m_ir % 64));
            chk("fetch_err", 32'(bus.fetch_err), 32'(m_err));
        end
    endtask

    task automatic model_step(input logic r, rdy, input logic [31:0] w,
                              input logic d, rd, input logic [31:0] rp);
        m_err = 0;
        if (r) begin
            m_known = 1; m_phase = 0; m_pc = RESET_PC; m_ir = 0; m_wait = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_wait = 0;
        end else if (m_phase == 1) begin
            m_wait++;
            if (rdy) begin
                m_ir = w; m_phase = 2;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (m_wait == TIMEOUT) begin
                m_ir = 0; m_err = 1; m_phase = 2;
            end
`endif
        end else if (d) begin
            m_pc    = rd ? (rp / 4) * 4 : m_pc + 4;
            m_phase = 1; m_wait = 0;
        end
    endtask

    // One clock: drive inputs mid-cycle, compare, then advance model at the edge.
    task automatic cyc(input logic r, rdy, input logic [31:0] w,
                       input logic d, rd, input logic [31:0] rp);
        @(negedge clk);
        rst = r; bus.MIO_ready = rdy; bus.inst_in = w;
        bus.inst_done = d; bus.redirect = rd; bus.redirect_pc = rp;
        #1 check_model();
        @(posedge clk);
        model_step(r, rdy, w, d, rd, rp);
    endtask

    initial begin
        rst = 1; bus.MIO_ready = 0; bus.inst_in = 0;
        bus.inst_done = 0; bus.redirect = 0; bus.redirect_pc = 0;

        // 1: reset, first fetch with word ready immediately
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        #1 chk("rst_ir_valid", 32'(bus.ir_valid), 0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        cyc(0, 1, 32'h0000_0020, 0, 0, 0);
        #1 chk("t1_mem_req", 32'(bus.mem_req), 1);
        chk("t1_pc", bus.PC_out, 0);
        cyc(0, 1, 32'h0000_0020, 0, 0, 0);
        #1 chk("t1_ir_valid", 32'(bus.ir_valid), 1);
        chk("t1_opcode", 32'(bus.OPcode), 0);
        chk("t1_fun", 32'(bus.Fun), 32'h20);

        // 2: sequential retire, then redirect with misaligned target
        cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
        #1 chk("t2_pc4", bus.PC_out, 32'h4);
        chk("t2_ir_valid", 32'(bus.ir_valid), 0);
        chk("t2_mem_req", 32'(bus.mem_req), 1);
        cyc(0, 1, 32'h8C22_0004, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h0000_0041);
        #1 chk("t2_redirect", bus.PC_out, 32'h40);

        // 3: stalled request, retire pulses ignored while waiting
        for (int i = 0; i < 5; i++) cyc(0, 0, 32'h1234_5678, i[0], 1, 32'h100);
        #1 chk("t3_mem_req", 32'(bus.mem_req), 1);
        chk("t3_pc", bus.PC_out, 32'h40);
        chk("t3_ir", bus.inst_out, 32'h8C22_0004);

        // 4: PC wrap at top of address space
        cyc(0, 1, 32'h0800_0010, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        cyc(0, 1, 32'h0000_0025, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        #1 chk("t4_wrap", bus.PC_out, 32'h0);

        // 5: reset while waiting, stray ready ignored
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'hCAFE_F00D, 0, 0, 0);
        #1 chk("t5_pc", bus.PC_out, RESET_PC);
        chk("t5_mem_req", 32'(bus.mem_req), 0);
        chk("t5_ir_valid", 32'(bus.ir_valid), 0);
        cyc(0, 1, 32'hCAFE_F00D, 0, 0, 0);
        #1 chk("t5_ir", bus.inst_out, 0);
        chk("t5_req", 32'(bus.mem_req), 1);

`ifdef FETCH_TIMEOUT_EN
        // 6: request times out after TIMEOUT cycles
        for (int i = 0; i < TIMEOUT; i++) cyc(0, 0, 32'hFFFF_FFFF, 0, 0, 0);
        #1 chk("t6_err", 32'(bus.fetch_err), 1);
        chk("t6_ir", bus.inst_out, 0);
        chk("t6_ir_valid", 32'(bus.ir_valid), 1);
        chk("t6_pc", bus.PC_out, RESET_PC);
        cyc(0, 0, 0, 0, 0, 0);
        #1 chk("t6_err_pulse", 32'(bus.fetch_err), 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 79) == 0),
                ($urandom_range(0, 3) == 0),
                $urandom(),
                ($urandom_range(0, 2) == 0),
                $urandom_range(0, 1),
                (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom()));
        end
        @(negedge clk);
        #1 check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
